// File: rtl/kalman_1d.sv
// -----------------------------------------------------------------------------
// kalman_1d
// Scalar fixed-point Kalman filter. Each accepted measurement z runs through
// predict (P += Q), a FRAC-cycle restoring divide for the gain
// K = P_pred / (P_pred + R), and an update of the estimate x and covariance P.
// One out_valid pulse is produced per accepted measurement. The input is
// back-pressured while a sample is in flight.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   meas_valid  measurement available
//   meas_ready  registered; high only while idle
//   meas_data   signed measurement z, Q(DATA_WIDTH-FRAC).FRAC
//   out_valid   one-cycle pulse when kalman_out/p_out are updated
//   kalman_out  signed filtered estimate x, held between pulses
//   p_out       current covariance P (debug)
// -----------------------------------------------------------------------------
module kalman_1d #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FRAC       = 8,
    parameter logic [DATA_WIDTH-1:0] Q_NOISE    = 16'h0010,
    parameter logic [DATA_WIDTH-1:0] R_NOISE    = 16'h0100,
    parameter logic [DATA_WIDTH-1:0] P_INIT     = 16'h0100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         meas_valid,
    output logic                         meas_ready,
    input  logic signed [DATA_WIDTH-1:0] meas_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] kalman_out,
    output logic        [DATA_WIDTH-1:0] p_out
);

    localparam int CNT_W  = $clog2(FRAC + 1);
    localparam int REM_W  = DATA_WIDTH + 2;
    localparam int PROD_W = DATA_WIDTH + FRAC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREDICT = 3'd1,
        ST_DIVIDE  = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] z_r;
    logic [DATA_WIDTH-1:0] p_pred_r;
    logic [DATA_WIDTH:0]   d_r;
    logic [REM_W-1:0]      rem_r;
    logic [FRAC-1:0]       quo_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [DATA_WIDTH-1:0]   p_pred_s;
    logic [DATA_WIDTH:0]     d_s;
    logic [REM_W-1:0]        rem_shift_s;
    logic [REM_W-1:0]        rem_next_s;
    logic                    rem_ge_s;
    logic signed [DATA_WIDTH:0] innov_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic [DATA_WIDTH-1:0]   x_new_s;
    logic [PROD_W-1:0]       kp_s;
    logic [DATA_WIDTH-1:0]   p_new_s;
    logic                    unused_bits_s;

    // Unsigned add clamped to all-ones on carry out.
    function automatic logic [DATA_WIDTH-1:0] sat_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DATA_WIDTH]) begin
            return '1;
        end else begin
            return sum[DATA_WIDTH-1:0];
        end
    endfunction

    // Datapath: predict, one divider step, and the update arithmetic.
    always_comb begin
        p_pred_s    = sat_add(p_out, Q_NOISE);
        d_s         = {1'b0, p_pred_s} + {1'b0, R_NOISE};
        rem_shift_s = {rem_r[REM_W-2:0], 1'b0};
        if (rem_shift_s >= {1'b0, d_r}) begin
            rem_ge_s   = 1'b1;
            rem_next_s = rem_shift_s - {1'b0, d_r};
        end else begin
            rem_ge_s   = 1'b0;
            rem_next_s = rem_shift_s;
        end
        innov_s = {z_r[DATA_WIDTH-1], z_r} - {kalman_out[DATA_WIDTH-1], kalman_out};
        // Product is only needed modulo 2^PROD_W: bits [PROD_W-1:FRAC] are the
        // floor-shifted step truncated to DATA_WIDTH, which is all we keep.
        prod_s  = PROD_W'(signed'({1'b0, quo_r})) * PROD_W'(innov_s);
        x_new_s = kalman_out + prod_s[PROD_W-1:FRAC];
        kp_s    = PROD_W'(quo_r) * PROD_W'(p_pred_r);
        p_new_s = p_pred_r - kp_s[PROD_W-1:FRAC];
    end

    // Fractional product bits and the remainder MSB (rem < D always) are discarded.
    assign unused_bits_s = ^{prod_s[FRAC-1:0], kp_s[FRAC-1:0], rem_r[REM_W-1]};

    // Control FSM and all state registers; kalman_out and p_out hold x and P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            z_r        <= '0;
            p_pred_r   <= '0;
            d_r        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            cnt_r      <= '0;
            meas_ready <= 1'b1;
            out_valid  <= 1'b0;
            kalman_out <= '0;
            p_out      <= P_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    if (meas_valid && meas_ready) begin
                        z_r        <= meas_data;
                        meas_ready <= 1'b0;
                        state_r    <= ST_PREDICT;
                    end
                end
                ST_PREDICT: begin
                    p_pred_r <= p_pred_s;
                    d_r      <= d_s;
                    rem_r    <= {2'b00, p_pred_s};
                    quo_r    <= '0;
                    cnt_r    <= '0;
                    state_r  <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[FRAC-2:0], rem_ge_s};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(FRAC - 1)) begin
                        state_r <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    kalman_out <= x_new_s;
                    p_out      <= p_new_s;
                    out_valid  <= 1'b1;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    out_valid  <= 1'b0;
                    meas_ready <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    out_valid  <= 1'b0;
                    meas_ready <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kalman_1d.md
# kalman_1d

Scalar fixed-point Kalman filter that fuses a stream of noisy sensor measurements into a filtered state estimate. It sits directly upstream of the fusion scoreboard and drives its `valid`/`kalman_out` pair one filtered sample per accepted measurement. Gain is computed per sample with an iterative restoring divider, so the block is multi-cycle and back-pressures its input.

## Interface

**Parameters**
- DATA_WIDTH, 16: width of measurement, estimate and covariance words.
- FRAC, 8: fractional bits; x is signed Q(DATA_WIDTH-FRAC).FRAC, P/Q/R unsigned same format.
- Q_NOISE, 16'h0010: process noise added to P each predict step.
- R_NOISE, 16'h0100: measurement noise; must be nonzero.
- P_INIT, 16'h0100: covariance after reset.

**Ports**
- Reset is `rst_n`, synchronous, active-low; clock is `clk`.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- meas_valid  in  1  measurement available.
- meas_ready  out  1  block can accept measurement (high only in IDLE).
- meas_data  in  DATA_WIDTH  signed measurement z.
- out_valid  out  1  one-cycle pulse: kalman_out updated.
- kalman_out  out  DATA_WIDTH  signed filtered estimate x, held between pulses.
- p_out  out  DATA_WIDTH  current covariance P (debug).

## Operation

- **Reset values:** state=IDLE, x=0, P=P_INIT, meas_ready=1, out_valid=0, kalman_out=0, p_out=P_INIT.
- **FSM:** IDLE -> PREDICT -> DIVIDE -> UPDATE -> DONE -> IDLE.
- **IDLE:** meas_ready=1; on meas_valid&&meas_ready, latch z and go to PREDICT.
- **PREDICT (1 cycle):**
  - P_pred = P + Q_NOISE, unsigned, saturating at 2^DATA_WIDTH-1.
  - D = P_pred + R_NOISE, DATA_WIDTH+1 bits, no overflow.
  - Divider remainder is initialised to P_pred, quotient to 0.
- **DIVIDE (exactly FRAC cycles):**
  - Each cycle: rem = rem<<1; if rem >= D then rem -= D and shift in quotient bit 1, else shift in 0. MSB first.
  - Remainder is DATA_WIDTH+2 bits.
  - Result: K = floor(P_pred·2^FRAC / D), range 0..2^FRAC-1.
- **UPDATE (1 cycle):**
  - innov = z - x, DATA_WIDTH+1 signed.
  - x_new = x + (K·innov >>> FRAC), arithmetic shift (floor).
  - Result lies within [min(x,z), max(x,z)], so no saturation is required; truncate to DATA_WIDTH.
  - P_new = P_pred - floor(K·P_pred / 2^FRAC).
  - Register x, P.
- **DONE (1 cycle):** out_valid=1, kalman_out=x, p_out=P; next cycle IDLE.
- **No output backpressure:** the consumer must accept every out_valid pulse.
- **meas_valid outside IDLE:** ignored. meas_ready is 0, so upstream must hold data.
- **meas_data:** sampled only on the accept edge; later changes are don't-care.
- **Reset mid-operation:** any state returns to IDLE with all reset values. The in-flight sample is dropped and no out_valid is produced.

## Timing

- Accept edge E0 (meas_valid&&meas_ready sampled high).
- After E0: PREDICT.
- After E1..E(FRAC+1): DIVIDE iterations.
- After E(FRAC+2): out_valid=1 with the new kalman_out (latency FRAC+2 cycles; 10 for FRAC=8).
- After E(FRAC+3): IDLE, meas_ready=1. The next accept is at E(FRAC+4) at the earliest, so minimum input period is FRAC+4 = 12 cycles.
- meas_ready is registered (decoded from state), with no combinational path from meas_valid.
- out_valid is high for exactly one cycle per accepted measurement.
- kalman_out and p_out change only in the cycle out_valid rises.

## Test plan

Defaults throughout: DATA_WIDTH=16, FRAC=8, Q=0x0010, R=0x0100, P_INIT=0x0100.

1. **Reset:** hold rst_n low 3 cycles -> kalman_out=0, out_valid=0, meas_ready=1, p_out=0x0100.
2. **First sample:** z=0x0A00 after reset -> intermediates P_pred=272, D=528, K=131. Outputs: out_valid exactly 10 cycles after the accept edge, kalman_out=0x051E (1310), p_out=133.
3. **Second sample:** z=0x0A00 again -> K=94, kalman_out=0x06E8 (1768), p_out=149-floor(94·149/256)=95. Then verify the estimate monotonically approaches 0x0A00 over 16 samples.
4. **Negative input:** z=0xF600 (-2560) after reset -> kalman_out=0xFAE2 (-1310), p_out=133.
5. **Backpressure:** hold meas_valid high continuously with changing meas_data -> meas_ready low for 11 of every 12 cycles. Exactly one out_valid per accept; only values present on accept edges are used.
6. **Mid-operation reset:** assert rst_n during DIVIDE -> no out_valid. State returns to reset values, and a following z=0x0A00 again yields 0x051E.
